// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
// Shared types for the rv32imc_ss load/store path.
//   lsu_width_e : access width encoding carried in req_type[1:0]
//   lsu_fault_e : retire status reported on the fault port
//   lsu_state_e : sequencer FSM states
//   REQ_*       : bit positions of the req_type fields
// ---------------------------------------------------------------------------
package rv32_pkg;

   typedef enum logic [1:0] {
      B = 2'd0,
      H = 2'd1,
      W = 2'd2
   } lsu_width_e;

   typedef enum logic [1:0] {
      NONE     = 2'd0,
      MISALIGN = 2'd1,
      BUS_ERR  = 2'd2,
      TIMEOUT  = 2'd3
   } lsu_fault_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RETIRE = 2'd3
   } lsu_state_e;

   localparam int unsigned REQ_WIDTH_LSB = 0;
   localparam int unsigned REQ_WIDTH_MSB = 1;
   localparam int unsigned REQ_ZEXT_BIT  = 2;

endpackage

// File: rtl/rv32_mod_lsu_sequencer_if.sv
// ---------------------------------------------------------------------------
// rv32_mod_lsu_sequencer_if
// Single-outstanding request/ack data bus between the LSU sequencer and the
// data-memory port.
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata : request, driven by the master
//   bus_ack/bus_err/bus_rdata                : response, driven by the slave
// ---------------------------------------------------------------------------
interface rv32_mod_lsu_sequencer_if;

   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic        bus_err;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ack, bus_err, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ack, bus_err, bus_rdata
   );

endinterface

// File: rtl/rv32_mod_lsu_align.sv
// ---------------------------------------------------------------------------
// rv32_mod_lsu_align
// Purely combinational byte-lane logic for the LSU.
//   st_off/st_width/st_data -> st_be, st_wdata, st_misalign
//       lane enables and replicated write data for a new request
//   ld_off/ld_width/ld_zext/ld_rdata -> ld_data
//       shift the read word down to the addressed byte and extend it
// ---------------------------------------------------------------------------
module rv32_mod_lsu_align
   import rv32_pkg::*;
(
   input  logic [1:0]  st_off,
   input  logic [1:0]  st_width,
   input  logic [31:0] st_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata,
   output logic        st_misalign,
   input  logic [1:0]  ld_off,
   input  logic [1:0]  ld_width,
   input  logic        ld_zext,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);

   logic [31:0] ld_shift_s;

   // Request lanes: enables follow the offset, data is replicated so every
   // enabled lane already carries the right byte.
   always_comb begin
      st_be       = 4'b0000;
      st_wdata    = st_data;
      st_misalign = 1'b0;
      case (st_width)
         B: begin
            st_be       = 4'b0001 << st_off;
            st_wdata    = {4{st_data[7:0]}};
            st_misalign = 1'b0;
         end
         H: begin
            st_be       = 4'b0011 << st_off;
            st_wdata    = {2{st_data[15:0]}};
            st_misalign = st_off[0];
         end
         W: begin
            st_be       = 4'b1111;
            st_wdata    = st_data;
            st_misalign = (st_off != 2'b00);
         end
         default: begin
            // width 3 is illegal; treat as a misaligned access so no bus cycle runs
            st_be       = 4'b0000;
            st_wdata    = st_data;
            st_misalign = 1'b1;
         end
      endcase
   end

   assign ld_shift_s = ld_rdata >> {ld_off, 3'b000};

   // Load extraction: take the low 8/16/32 bits of the shifted word and extend.
   always_comb begin
      ld_data = 32'h0000_0000;
      case (ld_width)
         B: begin
            if (ld_zext) ld_data = {24'h00_0000, ld_shift_s[7:0]};
            else         ld_data = {{24{ld_shift_s[7]}}, ld_shift_s[7:0]};
         end
         H: begin
            if (ld_zext) ld_data = {16'h0000, ld_shift_s[15:0]};
            else         ld_data = {{16{ld_shift_s[15]}}, ld_shift_s[15:0]};
         end
         W:       ld_data = ld_shift_s;
         default: ld_data = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/rv32_mod_lsu_sequencer.sv
// ---------------------------------------------------------------------------
// rv32_mod_lsu_sequencer
// Multi-cycle load/store sequencer: computes EA = base + immediate, runs one
// request on the data bus, extends load data and stalls the core until retire.
//   clk, rst                    : clock, synchronous active-high reset
//   start, is_store, req_type   : op launch (only honoured in IDLE)
//   base, immediate, store_data : rs1, offset, rs2
//   stall, done, fault          : core handshake; fault valid with done
//   load_data                   : extended load result, held between loads
//   bus                         : request/ack data-memory port (master side)
// TIMEOUT_CYCLES bounds the wait for bus_ack; 0 disables the watchdog.
// ---------------------------------------------------------------------------
module rv32_mod_lsu_sequencer
   import rv32_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_store,
   input  logic [3:0]  req_type,
   input  logic [31:0] base,
   input  logic [31:0] immediate,
   input  logic [31:0] store_data,
   output logic        stall,
   output logic        done,
   output logic [1:0]  fault,
   output logic [31:0] load_data,
   rv32_mod_lsu_sequencer_if.master bus
);

   lsu_state_e  state_r, state_s;
   lsu_fault_e  fault_r, fault_s;

   logic        is_store_r;
   logic [1:0]  width_r;
   logic        zext_r;
   logic [1:0]  off_r;
   logic [31:0] addr_r;
   logic [3:0]  be_r;
   logic [31:0] wdata_r;
   logic        we_r;
   logic [31:0] timer_r;
   logic [31:0] load_data_r;

   logic [31:0] ea_s;
   logic [1:0]  width_s;
   logic [3:0]  lane_be_s;
   logic [31:0] lane_wdata_s;
   logic        misalign_s;
   logic [31:0] load_ext_s;
   logic        timeout_s;
   logic        stall_s;
   logic        done_s;
   logic        bus_req_s;
   logic        unused_s;

   // Plain modulo-2^32 add: EA wraps with no overflow indication.
   assign ea_s     = base + immediate;
   assign width_s  = req_type[REQ_WIDTH_MSB:REQ_WIDTH_LSB];
   assign unused_s = req_type[3];

   // Watchdog fires on the last permitted WAIT cycle; an ack in that same
   // cycle is checked first in the FSM and therefore wins.
   assign timeout_s = (TIMEOUT_CYCLES != 32'd0) &&
                      (timer_r == (TIMEOUT_CYCLES - 32'd1));

   rv32_mod_lsu_align u_align (
      .st_off      (ea_s[1:0]),
      .st_width    (width_s),
      .st_data     (store_data),
      .st_be       (lane_be_s),
      .st_wdata    (lane_wdata_s),
      .st_misalign (misalign_s),
      .ld_off      (off_r),
      .ld_width    (width_r),
      .ld_zext     (zext_r),
      .ld_rdata    (bus.bus_rdata),
      .ld_data     (load_ext_s)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_s;
   end

   // FSM next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_s = misalign_s ? ST_RETIRE : ST_ISSUE;
            else       state_s = ST_IDLE;
         end
         ST_ISSUE: state_s = ST_WAIT;
         ST_WAIT: begin
            if (bus.bus_ack)    state_s = ST_RETIRE;
            else if (timeout_s) state_s = ST_RETIRE;
            else                state_s = ST_WAIT;
         end
         ST_RETIRE: state_s = ST_IDLE;
         default:   state_s = ST_IDLE;
      endcase
   end

   // FSM outputs: stall covers the start cycle combinationally through retire
   always_comb begin
      stall_s   = 1'b0;
      done_s    = 1'b0;
      fault_s   = NONE;
      bus_req_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) stall_s = 1'b1;
            else       stall_s = 1'b0;
         end
         ST_ISSUE, ST_WAIT: begin
            stall_s   = 1'b1;
            bus_req_s = 1'b1;
         end
         ST_RETIRE: begin
            stall_s = 1'b1;
            done_s  = 1'b1;
            fault_s = fault_r;
         end
         default: begin
            stall_s   = 1'b0;
            done_s    = 1'b0;
            fault_s   = NONE;
            bus_req_s = 1'b0;
         end
      endcase
   end

   // Op latches, bus request registers, wait timer and load result
   always_ff @(posedge clk) begin
      if (rst) begin
         fault_r     <= NONE;
         is_store_r  <= 1'b0;
         width_r     <= 2'b00;
         zext_r      <= 1'b0;
         off_r       <= 2'b00;
         addr_r      <= 32'h0000_0000;
         be_r        <= 4'b0000;
         wdata_r     <= 32'h0000_0000;
         we_r        <= 1'b0;
         timer_r     <= 32'h0000_0000;
         load_data_r <= 32'h0000_0000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  is_store_r <= is_store;
                  width_r    <= width_s;
                  zext_r     <= req_type[REQ_ZEXT_BIT];
                  off_r      <= ea_s[1:0];
                  timer_r    <= 32'h0000_0000;
                  if (misalign_s) begin
                     fault_r <= MISALIGN;
                     // a faulted load never returns stale data
                     if (!is_store) load_data_r <= 32'h0000_0000;
                  end else begin
                     fault_r <= NONE;
                     addr_r  <= {ea_s[31:2], 2'b00};
                     be_r    <= lane_be_s;
                     wdata_r <= lane_wdata_s;
                     we_r    <= is_store;
                  end
               end
            end
            ST_WAIT: begin
               if (bus.bus_ack) begin
                  if (bus.bus_err) begin
                     fault_r <= BUS_ERR;
                     if (!is_store_r) load_data_r <= 32'h0000_0000;
                  end else begin
                     fault_r <= NONE;
                     if (!is_store_r) load_data_r <= load_ext_s;
                  end
               end else if (timeout_s) begin
                  fault_r <= TIMEOUT;
                  if (!is_store_r) load_data_r <= 32'h0000_0000;
               end else begin
                  timer_r <= timer_r + 32'd1;
               end
            end
            default: begin
               timer_r <= timer_r;
            end
         endcase
      end
   end

   assign stall         = stall_s;
   assign done          = done_s;
   assign fault         = fault_s;
   assign load_data     = load_data_r;
   assign bus.bus_req   = bus_req_s;
   assign bus.bus_we    = we_r;
   assign bus.bus_addr  = addr_r;
   assign bus.bus_be    = be_r;
   assign bus.bus_wdata = wdata_r;

endmodule

// File: tb/tb_rv32_mod_lsu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rv32_mod_lsu_sequencer
// Self-checking bench for rv32_mod_lsu_sequencer (TIMEOUT_CYCLES = 4).
// Expected behaviour comes from a per-op reference model: byte lanes from the
// access size, retire cycle and fault from the ack delay, load result from
// shifting and extending the word seen at the ack.
// ---------------------------------------------------------------------------
module tb_rv32_mod_lsu_sequencer;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        is_store;
   logic [3:0]  req_type;
   logic [31:0] base;
   logic [31:0] immediate;
   logic [31:0] store_data;
   logic        stall;
   logic        done;
   logic [1:0]  fault;
   logic [31:0] load_data;

   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [31:0] exp_ld;

   rv32_mod_lsu_sequencer_if bus_if ();

   rv32_mod_lsu_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .is_store   (is_store),
      .req_type   (req_type),
      .base       (base),
      .immediate  (immediate),
      .store_data (store_data),
      .stall      (stall),
      .done       (done),
      .fault      (fault),
      .load_data  (load_data),
      .bus        (bus_if)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // One op end to end. ack_k = WAIT cycle index carrying the ack (-1 = never).
   // rd_val is the read word presented with the ack; other cycles carry noise.
   task automatic do_op(input string nm, input bit st, input logic [3:0] rt,
                        input logic [31:0] b, input logic [31:0] im,
                        input logic [31:0] sd, input int ack_k, input bit err,
                        input logic [31:0] rd_val, input bit poke);
      logic [31:0] ea, wd_e, ack_rd, tmp, v;
      logic [3:0]  be_e;
      int          size, off, done_c, f_e;
      bit          mis, ack_now, zx;
      ea   = b + im;
      off  = int'(ea[1:0]);
      zx   = rt[2];
      size = (rt[1:0] == 2'd0) ? 1 : (rt[1:0] == 2'd1) ? 2 : 4;
      mis  = (rt[1:0] == 2'd3) || ((off % size) != 0);
      for (int i = 0; i < 4; i++) begin
         be_e[i]         = (i >= off) && (i < off + size);
         wd_e[8*i +: 8]  = sd[8*(i % size) +: 8];
      end
      if (mis) begin
         done_c = 1; f_e = 1;
      end else if (ack_k >= 0 && ack_k <= TMO - 1) begin
         done_c = 3 + ack_k; f_e = err ? 2 : 0;
      end else begin
         done_c = 3 + TMO - 1; f_e = 3;
      end
      ack_rd = 32'h0;

      @(posedge clk); #1;
      start = 1'b1; is_store = st; req_type = rt; base = b; immediate = im;
      store_data = sd; bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0;
      @(negedge clk);
      tests_run++;
      if (stall !== 1'b1 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s start-cycle: stall=%b done=%b, required stall=1 done=0", nm, stall, done);
      end

      for (int c = 1; c <= done_c + 1; c++) begin
         @(posedge clk); #1;
         start      = poke && !mis && (c == 2);
         base       = $urandom; immediate = $urandom; store_data = $urandom;
         is_store   = 1'($urandom); req_type = 4'($urandom);
         bus_if.bus_rdata = (ack_k >= 0 && c == 2 + ack_k) ? rd_val : $urandom;
         ack_now    = (ack_k >= 0) && (c == 2 + ack_k);
         bus_if.bus_ack = ack_now;
         bus_if.bus_err = ack_now ? err : 1'($urandom);
         if (ack_now && c < done_c) ack_rd = bus_if.bus_rdata;
         @(negedge clk);
         if (c < done_c) begin
            tests_run++;
            if (stall !== 1'b1 || done !== 1'b0 || load_data !== exp_ld) begin
               tests_failed++;
               $display("FAIL %s busy c%0d: stall=%b done=%b ld=%h, required 1 0 %h", nm, c, stall, done, load_data, exp_ld);
            end
            tests_run++;
            if (bus_if.bus_req !== !mis) begin
               tests_failed++;
               $display("FAIL %s bus_req c%0d: got %b, required %b", nm, c, bus_if.bus_req, !mis);
            end
            if (!mis) begin
               tests_run++;
               if (bus_if.bus_addr !== {ea[31:2], 2'b00} || bus_if.bus_be !== be_e ||
                   bus_if.bus_wdata !== wd_e || bus_if.bus_we !== st) begin
                  tests_failed++;
                  $display("FAIL %s bus c%0d: addr=%h be=%b wd=%h we=%b, required %h %b %h %b", nm, c,
                           bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata, bus_if.bus_we,
                           {ea[31:2], 2'b00}, be_e, wd_e, st);
               end
            end
         end else if (c == done_c) begin
            if (!st) begin
               if (f_e != 0) v = 32'h0;
               else begin
                  tmp = ack_rd >> (8 * off);
                  if (size == 1) begin
                     v = tmp & 32'h0000_00FF;
                     if (!zx && v[7]) v = v | 32'hFFFF_FF00;
                  end else if (size == 2) begin
                     v = tmp & 32'h0000_FFFF;
                     if (!zx && v[15]) v = v | 32'hFFFF_0000;
                  end else v = tmp;
               end
               exp_ld = v;
            end
            tests_run++;
            if (done !== 1'b1 || stall !== 1'b1 || bus_if.bus_req !== 1'b0 || fault !== 2'(f_e)) begin
               tests_failed++;
               $display("FAIL %s retire: done=%b stall=%b req=%b fault=%0d, required 1 1 0 %0d", nm, done, stall, bus_if.bus_req, fault, f_e);
            end
            tests_run++;
            if (load_data !== exp_ld) begin
               tests_failed++;
               $display("FAIL %s load_data: got %h, required %h", nm, load_data, exp_ld);
            end
         end else begin
            tests_run++;
            if (done !== 1'b0 || stall !== 1'b0 || bus_if.bus_req !== 1'b0 || load_data !== exp_ld) begin
               tests_failed++;
               $display("FAIL %s post-retire: done=%b stall=%b req=%b ld=%h, required 0 0 0 %h", nm, done, stall, bus_if.bus_req, load_data, exp_ld);
            end
         end
      end
      start = 1'b0; bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; is_store = 1'b0; req_type = 4'd0;
      base = 32'h0; immediate = 32'h0; store_data = 32'h0;
      bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0; bus_if.bus_rdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if ({stall, done, fault, bus_if.bus_req, bus_if.bus_we} !== 6'b0 ||
          {bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata, load_data} !== 100'b0) begin
         tests_failed++;
         $display("FAIL reset: stall=%b done=%b fault=%0d req=%b we=%b addr=%h be=%b wd=%h ld=%h, required all zero",
                  stall, done, fault, bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata, load_data);
      end
      @(posedge clk); #1; rst = 1'b0;
      exp_ld = 32'h0;
   endtask

   task automatic test_loads;
      do_op("lw", 1'b0, 4'd2, 32'h0000_1000, 32'hFFFF_FFFC, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
      tests_run++;
      if (load_data !== 32'hDEAD_BEEF) begin
         tests_failed++; $display("FAIL lw-value: got %h, required deadbeef", load_data);
      end
      do_op("lb", 1'b0, 4'd0, 32'h0000_1000, 32'h3, 32'h0, 1, 1'b0, 32'h8011_2233, 1'b0);
      tests_run++;
      if (load_data !== 32'hFFFF_FF80) begin
         tests_failed++; $display("FAIL lb-value: got %h, required ffffff80", load_data);
      end
      do_op("lbu", 1'b0, 4'd4, 32'h0000_1000, 32'h3, 32'h0, 2, 1'b0, 32'h8011_2233, 1'b0);
      tests_run++;
      if (load_data !== 32'h0000_0080) begin
         tests_failed++; $display("FAIL lbu-value: got %h, required 00000080", load_data);
      end
      do_op("lh2", 1'b0, 4'd1, 32'h0000_2000, 32'h2, 32'h0, 0, 1'b0, 32'h9234_5678, 1'b0);
      do_op("lhu0", 1'b0, 4'd5, 32'h0000_2000, 32'h0, 32'h0, 0, 1'b0, 32'h1234_8678, 1'b0);
   endtask

   task automatic test_store;
      exp_ld = load_data;
      do_op("sh", 1'b1, 4'd1, 32'h0000_2000, 32'h2, 32'h0000_ABCD, 0, 1'b0, 32'h0, 1'b0);
      do_op("sb", 1'b1, 4'd0, 32'h0000_2001, 32'h0, 32'h0000_0011, 1, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic test_misaligned;
      do_op("lw-mis", 1'b0, 4'd2, 32'h0000_2000, 32'h2, 32'h0, 0, 1'b0, 32'h0, 1'b0);
      do_op("sh-mis", 1'b1, 4'd1, 32'h0000_2001, 32'h0, 32'h0, 0, 1'b0, 32'h0, 1'b0);
      do_op("w3", 1'b0, 4'd3, 32'h0000_2000, 32'h0, 32'h0, 0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic test_timeout_err;
      do_op("lw-ok", 1'b0, 4'd2, 32'h40, 32'h0, 32'h0, 0, 1'b0, 32'h1357_9BDF, 1'b0);
      do_op("timeout", 1'b0, 4'd2, 32'h40, 32'h0, 32'h0, -1, 1'b0, 32'h0, 1'b0);
      do_op("ack-at-limit", 1'b0, 4'd2, 32'h40, 32'h0, 32'h0, TMO - 1, 1'b0, 32'hCAFE_F00D, 1'b0);
      do_op("late-ack", 1'b1, 4'd2, 32'h40, 32'h0, 32'h5, TMO, 1'b0, 32'h0, 1'b0);
      do_op("bus-err", 1'b0, 4'd2, 32'h40, 32'h0, 32'h0, 1, 1'b1, 32'hFFFF_FFFF, 1'b0);
   endtask

   task automatic test_rst_mid_and_poke;
      @(posedge clk); #1;
      start = 1'b1; is_store = 1'b0; req_type = 4'd2; base = 32'h3000; immediate = 32'h0;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      bus_if.bus_ack = 1'b1; bus_if.bus_err = 1'b0; bus_if.bus_rdata = 32'h7777_7777;
      @(negedge clk);
      tests_run++;
      if ({stall, done, fault, bus_if.bus_req, bus_if.bus_we} !== 6'b0 ||
          {bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata, load_data} !== 100'b0) begin
         tests_failed++;
         $display("FAIL rst-mid: stall=%b done=%b fault=%0d req=%b addr=%h ld=%h, required all zero",
                  stall, done, fault, bus_if.bus_req, bus_if.bus_addr, load_data);
      end
      @(posedge clk); #1; bus_if.bus_ack = 1'b0;
      @(negedge clk);
      tests_run++;
      if (done !== 1'b0 || stall !== 1'b0 || bus_if.bus_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst-mid-ack: done=%b stall=%b req=%b, required 0 0 0", done, stall, bus_if.bus_req);
      end
      exp_ld = 32'h0;
      do_op("after-rst", 1'b0, 4'd1, 32'h3000, 32'h2, 32'h0, 0, 1'b0, 32'hA5A5_1234, 1'b0);
      do_op("poke", 1'b0, 4'd2, 32'h5000, 32'h8, 32'h0, 2, 1'b0, 32'h0BAD_CAFE, 1'b1);
   endtask

   task automatic test_random;
      logic [31:0] b, im;
      logic [3:0]  rt;
      int          ak;
      for (int n = 0; n < 150; n++) begin
         rt = 4'($urandom);
         if ($urandom_range(0, 7) != 0 && rt[1:0] == 2'd3) rt[1:0] = 2'd2;
         b  = $urandom;
         im = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            im[1:0] = 2'b00;
            if (rt[1:0] == 2'd2) b[1:0] = 2'b00;
            if (rt[1:0] == 2'd1) b[0]   = 1'b0;
         end
         ak = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
         do_op("rand", 1'($urandom), rt, b, im, $urandom, ak,
               ($urandom_range(0, 4) == 0), $urandom, ($urandom_range(0, 5) == 0));
      end
   endtask

   task automatic test_back_to_back;
      do_op("b2b-sw", 1'b1, 4'd2, 32'h100, 32'h4, 32'h0102_0304, 0, 1'b0, 32'h0, 1'b0);
      do_op("b2b-lw", 1'b0, 4'd2, 32'h100, 32'h4, 32'h0, 0, 1'b0, 32'h0102_0304, 1'b0);
      do_op("b2b-lb", 1'b0, 4'd0, 32'h100, 32'h5, 32'h0, 0, 1'b0, 32'h0000_FE00, 1'b0);
   endtask

   initial begin
      test_reset();
      test_loads();
      test_store();
      test_misaligned();
      test_timeout_err();
      test_rst_mid_and_poke();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
